// File: rtl/axis_padder.sv
// ---------------------------------------------------------------------------
// axis_padder
//
// Pads short AXI-Stream packets up to MIN_BEATS beats. Fill beats go after
// the source's last beat. Real data passes through with zero latency and no
// buffering. Fill beats are made locally from PAD_BYTE and the tuser of the
// packet's last accepted beat.
//
// Optional feature (compile-time macro AXIS_PADDER_MAX_LEN_EN):
//   When defined, packets are truncated at MAX_BEATS beats. The output tlast
//   is forced on beat MAX_BEATS. Any further input beats of that packet are
//   accepted and dropped (DROP state). When undefined, MAX_BEATS only sizes
//   the beat counter and packets of any length pass through.
//
// Parameters:
//   AXIS_BYTES      tdata width in bytes (all beats full)
//   AXIS_USER_BITS  tuser width
//   MIN_BEATS       minimum output packet length in beats (>= 1)
//   PAD_BYTE        byte value replicated across tdata in fill beats
//   MAX_BEATS       truncation length, used only with the optional feature
//
// Ports:
//   clk, sresetn            clock; synchronous active-low reset
//   axis_i_*                AXI-Stream slave (upstream source)
//   axis_o_*                AXI-Stream master (downstream, e.g. spacer)
//
// Handshake: a beat transfers on a rising clk edge when tvalid && tready are
// both high on that interface. A master never makes tvalid depend on tready.
// Once this block raises axis_o_tvalid for a fill beat, it holds tvalid and
// the beat contents stable until the beat transfers. In PASS the upstream
// source provides this stability for real beats.
// ---------------------------------------------------------------------------
module axis_padder #(
  parameter int          AXIS_BYTES     = 1,
  parameter int          AXIS_USER_BITS = 1,
  parameter int          MIN_BEATS      = 60,
  parameter logic [7:0]  PAD_BYTE       = 8'h00,
  parameter int          MAX_BEATS      = 1514
) (
  input  logic                        clk,
  input  logic                        sresetn,
  output logic                        axis_i_tready,
  input  logic                        axis_i_tvalid,
  input  logic                        axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]   axis_i_tuser,
  input  logic                        axis_o_tready,
  output logic                        axis_o_tvalid,
  output logic                        axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]     axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]   axis_o_tuser
);

  // The counter must reach MIN_BEATS-1 for padding. With the optional
  // feature it must also reach MAX_BEATS-1. Size for the larger of the two.
  localparam int CTR_TOP = (MIN_BEATS > MAX_BEATS) ? MIN_BEATS : MAX_BEATS;
  localparam int CTR_W   = $clog2(CTR_TOP + 1);

  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_SAT  = '1;
  localparam logic [CTR_W-1:0] MIN_M1   = CTR_W'(MIN_BEATS - 1);
`ifdef AXIS_PADDER_MAX_LEN_EN
  localparam logic [CTR_W-1:0] MAX_M1   = CTR_W'(MAX_BEATS - 1);
`endif

  localparam logic [AXIS_BYTES*8-1:0] FILL_DATA = {AXIS_BYTES{PAD_BYTE}};

`ifdef AXIS_PADDER_MAX_LEN_EN
  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_t;
`endif

  state_t                      state_q, state_d;
  logic [CTR_W-1:0]            ctr_q, ctr_d;
  logic [AXIS_USER_BITS-1:0]   user_q, user_d;

  logic                        in_xfer;
  logic                        out_xfer;
  logic [CTR_W-1:0]            ctr_inc;

  // Transfers are defined on the ports as driven, so both depend on the
  // combinational outputs below.
  assign in_xfer  = axis_i_tvalid && axis_i_tready;
  assign out_xfer = axis_o_tvalid && axis_o_tready;

  // The saturating increment keeps a very long packet (feature disabled)
  // from wrapping ctr back into the "short packet" range.
  assign ctr_inc = (ctr_q == CTR_SAT) ? ctr_q : (ctr_q + CTR_ONE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= ST_PASS;
      ctr_q   <= CTR_ZERO;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      user_q  <= user_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    user_d        = user_q;
    axis_i_tready = axis_o_tready;
    axis_o_tvalid = axis_i_tvalid;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = axis_i_tdata;
    axis_o_tuser  = axis_i_tuser;

    case (state_q)
      ST_PASS: begin
        // Mask the source's tlast if the packet is still short. The fill
        // beats will carry tlast instead.
        axis_o_tlast = axis_i_tlast && (ctr_q >= MIN_M1);
`ifdef AXIS_PADDER_MAX_LEN_EN
        if (ctr_q == MAX_M1) begin
          axis_o_tlast = 1'b1;
        end
`endif
        if (in_xfer) begin
          user_d = axis_i_tuser;
          if (axis_i_tlast) begin
            if (ctr_q < MIN_M1) begin
              // ctr now holds the beats sent so far, which is also the
              // index of the first fill beat.
              ctr_d   = ctr_inc;
              state_d = ST_PAD;
            end else begin
              ctr_d = CTR_ZERO;
            end
          end else begin
            ctr_d = ctr_inc;
`ifdef AXIS_PADDER_MAX_LEN_EN
            if (ctr_q == MAX_M1) begin
              state_d = ST_DROP;
            end
`endif
          end
        end
      end

      ST_PAD: begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = FILL_DATA;
        axis_o_tuser  = user_q;
        axis_o_tlast  = (ctr_q == MIN_M1);
        if (out_xfer) begin
          if (ctr_q == MIN_M1) begin
            ctr_d   = CTR_ZERO;
            state_d = ST_PASS;
          end else begin
            ctr_d = ctr_inc;
          end
        end
      end

`ifdef AXIS_PADDER_MAX_LEN_EN
      ST_DROP: begin
        // Swallow the rest of an over-long packet. The downstream side has
        // already seen its tlast.
        axis_i_tready = 1'b1;
        axis_o_tvalid = 1'b0;
        if (in_xfer && axis_i_tlast) begin
          ctr_d   = CTR_ZERO;
          state_d = ST_PASS;
        end
      end
`endif

      default: begin
        state_d = ST_PASS;
        ctr_d   = CTR_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_padder.sv
module tb_axis_padder;

  localparam int BYTES     = 1;
  localparam int UBITS     = 1;
  localparam int MIN_BEATS = 4;
  localparam int MAX_BEATS = 6;
  localparam int DW        = BYTES * 8;
  localparam int EW        = 1 + UBITS + DW;   // {tlast, tuser, tdata}
  localparam logic [7:0] PAD_BYTE = 8'h00;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic sresetn;
  always #5 clk = ~clk;

  logic             axis_i_tready, axis_i_tvalid, axis_i_tlast;
  logic [DW-1:0]    axis_i_tdata;
  logic [UBITS-1:0] axis_i_tuser;
  logic             axis_o_tready, axis_o_tvalid, axis_o_tlast;
  logic [DW-1:0]    axis_o_tdata;
  logic [UBITS-1:0] axis_o_tuser;

  axis_padder #(
    .AXIS_BYTES     (BYTES),
    .AXIS_USER_BITS (UBITS),
    .MIN_BEATS      (MIN_BEATS),
    .PAD_BYTE       (PAD_BYTE),
    .MAX_BEATS      (MAX_BEATS)
  ) dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tready (axis_i_tready),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tdata  (axis_i_tdata),
    .axis_i_tuser  (axis_i_tuser),
    .axis_o_tready (axis_o_tready),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tdata  (axis_o_tdata),
    .axis_o_tuser  (axis_o_tuser)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];

  // Reference model: one packet in, the expected output beats pushed out.
  // The first min(N, MAX) source beats pass unchanged (MAX only with the
  // feature). Short packets get MIN-N fill beats carrying the last user
  // value. tlast goes on the final output beat only.
  task automatic model_packet(input int n, input logic [DW-1:0] d[16], input logic [UBITS-1:0] u[16]);
    int n_out, n_tot;
    n_out = n;
`ifdef AXIS_PADDER_MAX_LEN_EN
    if (n_out > MAX_BEATS) n_out = MAX_BEATS;
`endif
    n_tot = (n_out < MIN_BEATS) ? MIN_BEATS : n_out;
    for (int i = 0; i < n_tot; i++) begin
      logic          last;
      logic [DW-1:0] dd;
      logic [UBITS-1:0] uu;
      last = (i == n_tot - 1);
      if (i < n_out) begin
        dd = d[i];
        uu = u[i];
      end else begin
        dd = {BYTES{PAD_BYTE}};
        uu = u[n - 1];
      end
      exp_q.push_back({last, uu, dd});
    end
  endtask

  // Monitor: samples at negedge; a transfer happens on the following posedge.
  logic          prev_stall = 1'b0;
  logic [EW+0:0] prev_out;
  initial begin
    forever begin
      @(negedge clk);
      if (!sresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_stable", {31'd0, axis_o_tvalid, axis_o_tlast, axis_o_tuser, axis_o_tdata},
                {31'd0, prev_out});
        end
        if (axis_o_tvalid && axis_o_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {22'd0, axis_o_tlast, axis_o_tuser, axis_o_tdata}, 32'hFFFF_FFFF);
          end else begin
            check("out_beat", {22'd0, axis_o_tlast, axis_o_tuser, axis_o_tdata}, {22'd0, exp_q.pop_front()});
          end
        end
        prev_stall = axis_o_tvalid && !axis_o_tready;
        prev_out   = {axis_o_tvalid, axis_o_tlast, axis_o_tuser, axis_o_tdata};
      end
    end
  end

  // Downstream ready generator: 0 = always ready, 1 = toggle, 2 = random.
  int rdy_mode = 0;
  initial begin
    axis_o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       axis_o_tready = ~axis_o_tready;
        2:       axis_o_tready = ($urandom_range(0, 3) != 0);
        default: axis_o_tready = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------- driver
  // user_sel < 0 picks random tuser per beat, else fixed value.
  task automatic send_pkt(input int n, input int user_sel, input int gap_max, output int stalls);
    logic [DW-1:0]    d[16];
    logic [UBITS-1:0] u[16];
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      d[i] = DW'($urandom);
      u[i] = (user_sel < 0) ? UBITS'($urandom) : UBITS'(user_sel);
    end
    model_packet(n, d, u);
    for (int b = 0; b < n; b++) begin
      int g;
      int budget;
      logic hs;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      axis_i_tvalid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = d[b];
      axis_i_tuser  = u[b];
      axis_i_tlast  = (b == n - 1);
      budget = 0;
      forever begin
        @(negedge clk);
        hs = axis_i_tready;
        @(posedge clk);
        #1;
        if (hs) break;
        stalls++;
        budget++;
        if (budget > 500) begin
          check("drv_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int st, st2, cnt;
    sresetn       = 1'b0;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    axis_i_tdata  = '0;
    axis_i_tuser  = '0;

    // Reset state: pass-through, nothing valid out.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovalid", {31'd0, axis_o_tvalid}, 32'd0);
    check("rst_iready", {31'd0, axis_i_tready}, {31'd0, axis_o_tready});
    @(posedge clk);
    #1;
    sresetn = 1'b1;

    // 2-beat packet padded to 4; input stalled exactly 2 cycles for fill.
    send_pkt(2, -1, 0, st);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axis_i_tready) break;
      cnt++;
    end
    check("pad2_stall_cycles", cnt, 32'd2);
    @(posedge clk);
    #1;

    // 4-beat then 6-beat packets: unchanged, no bubbles.
    send_pkt(4, -1, 0, st);
    check("pkt4_no_stall", st, 32'd0);
    send_pkt(6, -1, 0, st);
    check("pkt6_no_stall", st, 32'd0);

    // 1-beat packet, tuser=1, downstream toggling ready.
    rdy_mode = 1;
    send_pkt(1, 1, 0, st);
    repeat (12) @(posedge clk);
    #1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back 1-beat then 5-beat: second packet waits exactly 3 fill beats.
    send_pkt(1, -1, 0, st);
    send_pkt(5, -1, 0, st2);
    check("b2b_first_accept", st2, 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Reset after one fill beat, then a fresh 1-beat packet gets full padding.
    send_pkt(1, -1, 0, st);
    @(posedge clk);
    #1;
    sresetn = 1'b0;
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_iready", {31'd0, axis_i_tready}, {31'd0, axis_o_tready});
    check("post_rst_ovalid", {31'd0, axis_o_tvalid}, 32'd0);
    @(posedge clk);
    #1;
    send_pkt(1, -1, 0, st);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axis_i_tready) break;
      cnt++;
    end
    check("post_rst_pad_cycles", cnt, 32'd3);
    @(posedge clk);
    #1;

`ifdef AXIS_PADDER_MAX_LEN_EN
    // Over-long packet truncated at MAX_BEATS, then a short one still padded.
    send_pkt(9, -1, 0, st);
    check("trunc_no_stall", st, 32'd0);
    send_pkt(2, -1, 0, st);
    repeat (6) @(posedge clk);
    #1;
`endif

    // Randomized traffic against the model.
    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      send_pkt($urandom_range(1, 9), -1, $urandom_range(0, 2), st);
    end

    // Drain.
    rdy_mode = 0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_padder.md
Name: axis_padder

Overview:
- Pads short AXI-Stream packets up to a minimum length in beats by appending fill beats after the source's last beat.
- Sits directly upstream of the inter-packet spacer in the transmit path (e.g. Ethernet minimum frame), so the spacer only sees conforming packets.
- Zero-latency pass-through for real data; no buffering. Fill beats are generated locally.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes; all beats are full.
- AXIS_USER_BITS, 1, tuser width.
- MIN_BEATS, 60, minimum output packet length in beats; must be >= 1. A value of 1 gives pure pass-through.
- PAD_BYTE, 8'h00, byte value replicated AXIS_BYTES times in fill beats.
- MAX_BEATS, 1514, maximum packet length in beats; used only with the optional feature; must be >= MIN_BEATS.

Ports:
- clk  in  1  clock
- sresetn  in  1  reset, synchronous, active-low
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  input last
- axis_i_tdata  in  AXIS_BYTES*8  input data
- axis_i_tuser  in  AXIS_USER_BITS  input user
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  output last
- axis_o_tdata  out  AXIS_BYTES*8  output data
- axis_o_tuser  out  AXIS_USER_BITS  output user

Behaviour:
- Clock is clk; reset is sresetn, synchronous, active-low.
- Registers:
  - state, values PASS or PAD; DROP is added only with the optional feature.
  - ctr, the beat count within the current packet, width $clog2(max(MIN_BEATS,MAX_BEATS)+1); saturates at its maximum.
  - user_q, holding tuser of the last accepted input beat.
- Reset:
  - state=PASS, ctr=0, user_q=0.
  - Outputs are combinational from state, so after reset they pass input through.
- PASS:
  - axis_i_tready=axis_o_tready; axis_o_tvalid=axis_i_tvalid; tdata and tuser pass straight through.
  - axis_o_tlast = axis_i_tlast && (ctr >= MIN_BEATS-1).
  - Latency is 0.
- PASS transitions, on an input transfer (tvalid && tready):
  - user_q <= axis_i_tuser.
  - If tlast and ctr < MIN_BEATS-1: ctr <= ctr+1, go to PAD.
  - If tlast otherwise: ctr <= 0, stay in PASS.
  - Not tlast: ctr <= ctr+1 (saturating).
- PAD:
  - axis_i_tready=0; axis_o_tvalid=1.
  - tdata = {AXIS_BYTES{PAD_BYTE}}; tuser = user_q; axis_o_tlast = (ctr == MIN_BEATS-1).
  - Output is held stable while axis_o_tready=0.
  - On each output transfer ctr <= ctr+1.
  - On the transfer with tlast=1: ctr <= 0, go to PASS. The next packet's first beat can transfer on the following cycle.
- Packets of >= MIN_BEATS beats are passed unchanged, with no bubble.
- Packets of N < MIN_BEATS beats produce exactly MIN_BEATS-N fill beats.
- Reset mid-packet or mid-pad:
  - Immediate return to PASS with ctr=0.
  - The truncated packet downstream is accepted behaviour; the next packet is handled from its first beat.
- tvalid is never withdrawn once asserted in PAD.

Optional Feature:
- Macro: AXIS_PADDER_MAX_LEN_EN.
- Defined:
  - Packets are truncated at MAX_BEATS.
  - In PASS, when ctr == MAX_BEATS-1, axis_o_tlast is forced to 1.
  - If that beat transfers with axis_i_tlast=0, go to DROP.
- DROP state:
  - axis_i_tready=1, axis_o_tvalid=0; input beats are discarded.
  - On an accepted beat with axis_i_tlast=1: ctr <= 0, go to PASS.
  - Reset in DROP returns to PASS; the remaining input beats of that packet are then treated as a new packet.
- Undefined:
  - No DROP state; MAX_BEATS is ignored; arbitrarily long packets pass through.

Test Plan:
- MIN_BEATS=4, 1-byte beats, always ready; send A1,A2(tlast) -> out A1,A2,00,00; tlast only on 4th; axis_i_tready=0 for exactly 2 cycles.
- 4-beat packet B1..B4, then 6-beat packet -> both unchanged; tlast on beat 4 and beat 6 respectively; no idle cycles.
- 1-beat packet C1 with tuser=1, axis_o_tready toggling 1,0,1,0 -> 4 output beats; fill beats hold 00 and tuser=1 while stalled; tlast on 4th.
- Back-to-back 1-beat then 5-beat packets with continuous tvalid -> first input beat of packet 2 accepted the cycle after the pad tlast transfer; packet 2 unpadded.
- Reset asserted for 1 cycle after 1 fill beat -> state PASS; following 1-beat packet is padded to the full 4 beats.
- With AXIS_PADDER_MAX_LEN_EN, MAX_BEATS=6: 9-beat packet -> 6 beats out, tlast on 6th; beats 7-9 accepted and not output; next 2-beat packet padded to 4.
